// File: rtl/memory_access_unit_if.sv
// Memory-side req/ack bus between the MAR/MDR sequencer and the external memory wrapper.
interface memory_access_unit_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_req,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_req,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/memory_access_unit.sv
// LC-3 MAR/MDR sequencer: latches bus values, runs one req/ack memory access,
// returns read data in MDR and pulses ready (with err on timeout).
module memory_access_unit #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [15:0]           i_bus_in,
    input  logic                  i_ld_mar,
    input  logic                  i_ld_mdr,
    input  logic                  i_mem_en,
    input  logic                  i_r_w,
    output logic [15:0]           o_mar_out,
    output logic [15:0]           o_mdr_out,
    output logic                  o_ready,
    output logic                  o_err,
    output logic                  o_busy,
    memory_access_unit_if.master  mem
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [WAIT_W-1:0] LP_MAX_WAIT = WAIT_W'(MAX_WAIT);

    state_t            r_state, w_state_nxt;
    logic [15:0]       r_mar, r_mdr, r_mem_addr, r_mem_wdata;
    logic              r_mem_we, r_mem_req, r_ready, r_err, r_timed_out;
    logic [WAIT_W-1:0] r_wait;
    logic              w_ack, w_timeout;

    assign w_ack     = (r_state == S_ACCESS) && mem.mem_ack;
    assign w_timeout = (r_state == S_ACCESS) && !mem.mem_ack && (r_wait == LP_MAX_WAIT);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_mem_en) w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_ack || w_timeout) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mar       <= 16'h0000;
            r_mdr       <= 16'h0000;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 16'h0000;
            r_mem_we    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_timed_out <= 1'b0;
            r_wait      <= '0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_ld_mar) r_mar <= i_bus_in;
                    if (i_ld_mdr) r_mdr <= i_bus_in;
                    if (i_mem_en) begin
                        // Forward a same-cycle MAR/MDR load straight onto the memory bus
                        r_mem_addr  <= i_ld_mar ? i_bus_in : r_mar;
                        r_mem_wdata <= i_ld_mdr ? i_bus_in : r_mdr;
                        r_mem_we    <= i_r_w;
                        r_mem_req   <= 1'b1;
                        r_wait      <= '0;
                        r_timed_out <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    if (w_ack) begin
                        if (!r_mem_we) r_mdr <= mem.mem_rdata;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end else if (w_timeout) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_timed_out <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_err   <= r_timed_out;
                end
                default: ;
            endcase
        end
    end

    assign o_mar_out     = r_mar;
    assign o_mdr_out     = r_mdr;
    assign o_ready       = r_ready;
    assign o_err         = r_err;
    assign o_busy        = (r_state != S_IDLE);
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_req   = r_mem_req;
endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: directed scenarios plus random accesses against a MAR/MDR model.
module tb_memory_access_unit;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_in;
    logic        ld_mar, ld_mdr, mem_en, r_w;
    logic [15:0] mar_out, mdr_out;
    logic        ready, err, busy;

    memory_access_unit_if mif();

    memory_access_unit #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_bus_in(bus_in), .i_ld_mar(ld_mar), .i_ld_mdr(ld_mdr),
        .i_mem_en(mem_en), .i_r_w(r_w), .o_mar_out(mar_out), .o_mdr_out(mdr_out),
        .o_ready(ready), .o_err(err), .o_busy(busy), .mem(mif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state of the architectural registers
    logic [15:0] mar_m, mdr_m;

    // Observations gathered by the access driver
    logic [15:0] o_addr, o_wdata;
    logic        o_we, o_req, o_req_end, o_busy_end, o_err_at;
    int          o_rdy_cyc, o_rdy_cnt, o_err_cnt;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_mar = 0; ld_mdr = 0; mem_en = 0; r_w = 0; bus_in = 16'h0000;
        mif.mem_ack = 0; mif.mem_rdata = 16'h0000;
    endtask

    // Drives one access; memory acks so that ack is sampled after `delay` wait cycles
    // (delay < 0 means never). Optional junk in ACCESS: ld_mar/ld_mdr/mem_en.
    task automatic do_access(input logic lmar, input logic lmdr, input logic rw,
                             input logic [15:0] bus, input int delay,
                             input logic [15:0] rdata, input logic inject);
        bus_in = bus; ld_mar = lmar; ld_mdr = lmdr; mem_en = 1; r_w = rw;
        step();
        idle_inputs();
        o_addr = mif.mem_addr; o_wdata = mif.mem_wdata; o_we = mif.mem_we; o_req = mif.mem_req;
        o_rdy_cyc = -1; o_rdy_cnt = 0; o_err_cnt = 0; o_err_at = 0;
        for (int c = 0; c < MAX_WAIT + 6; c++) begin
            if (ready) begin
                o_rdy_cnt++;
                if (o_rdy_cyc < 0) begin o_rdy_cyc = c; o_err_at = err; end
            end
            if (err) o_err_cnt++;
            mif.mem_ack   = (c == delay);
            mif.mem_rdata = (c == delay) ? rdata : 16'($urandom);
            if (inject && c == 1) begin
                ld_mar = 1; ld_mdr = 1; mem_en = 1; bus_in = 16'hFFFF; r_w = ~rw;
            end
            step();
            idle_inputs();
        end
        o_req_end = mif.mem_req; o_busy_end = busy;
    endtask

    function automatic int exp_ready_cyc(input int delay);
        return (delay >= 0 && delay <= MAX_WAIT) ? delay + 2 : MAX_WAIT + 2;
    endfunction

    task automatic test_reset();
        rst = 1; idle_inputs();
        step(); step();
        total++; if ({mar_out, mdr_out} !== 32'h0) begin bad++; $display("FAIL reset_regs mar=%h mdr=%h exp 0", mar_out, mdr_out); end
        total++; if ({ready, err, busy, mif.mem_req, mif.mem_we} !== 5'b0) begin bad++; $display("FAIL reset_flags rdy/err/busy/req/we=%b exp 00000", {ready, err, busy, mif.mem_req, mif.mem_we}); end
        total++; if ({mif.mem_addr, mif.mem_wdata} !== 32'h0) begin bad++; $display("FAIL reset_bus addr=%h wdata=%h exp 0", mif.mem_addr, mif.mem_wdata); end
        rst = 0; step();
        // Reset in the middle of an access that never gets an ack
        bus_in = 16'h1111; ld_mar = 1; mem_en = 1; r_w = 0;
        step(); idle_inputs();
        total++; if (mif.mem_req !== 1'b1) begin bad++; $display("FAIL rst_mid_req_start req=%b exp 1", mif.mem_req); end
        step(); step(); step();
        rst = 1; step(); rst = 0;
        total++; if ({mif.mem_req, busy} !== 2'b00) begin bad++; $display("FAIL rst_mid_req req/busy=%b exp 00", {mif.mem_req, busy}); end
        begin
            int pulses = 0;
            for (int c = 0; c < MAX_WAIT + 4; c++) begin
                if (ready || err) pulses++;
                step();
            end
            total++; if (pulses != 0) begin bad++; $display("FAIL rst_mid_no_ready pulses=%0d exp 0", pulses); end
        end
        mar_m = 16'h0000; mdr_m = 16'h0000;
    endtask

    task automatic test_reg_load();
        bus_in = 16'hA5A5; ld_mar = 1; step(); idle_inputs();
        total++; if (mar_out !== 16'hA5A5 || mdr_out !== 16'h0000) begin bad++; $display("FAIL ld_mar mar=%h mdr=%h exp a5a5/0000", mar_out, mdr_out); end
        bus_in = 16'h5A5A; ld_mar = 1; ld_mdr = 1; step(); idle_inputs();
        total++; if (mar_out !== 16'h5A5A || mdr_out !== 16'h5A5A) begin bad++; $display("FAIL ld_both mar=%h mdr=%h exp 5a5a/5a5a", mar_out, mdr_out); end
        mar_m = 16'h5A5A; mdr_m = 16'h5A5A;
    endtask

    task automatic test_read_zero_wait();
        bus_in = 16'h3000; ld_mar = 1; step(); idle_inputs();
        do_access(0, 0, 0, 16'h0000, 0, 16'h1234, 0);
        total++; if ({o_addr, o_we, o_req} !== {16'h3000, 1'b0, 1'b1}) begin bad++; $display("FAIL read0_bus addr=%h we=%b req=%b exp 3000/0/1", o_addr, o_we, o_req); end
        total++; if (o_rdy_cyc != 2 || o_rdy_cnt != 1) begin bad++; $display("FAIL read0_ready cyc=%0d cnt=%0d exp 2/1", o_rdy_cyc, o_rdy_cnt); end
        total++; if (mdr_out !== 16'h1234 || o_err_cnt != 0) begin bad++; $display("FAIL read0_mdr mdr=%h errs=%0d exp 1234/0", mdr_out, o_err_cnt); end
        mar_m = 16'h3000; mdr_m = 16'h1234;
    endtask

    task automatic test_write_wait3();
        bus_in = 16'hBEEF; ld_mdr = 1; step(); idle_inputs();
        do_access(1, 0, 1, 16'h4001, 3, 16'hDEAD, 0);
        total++; if ({o_addr, o_wdata, o_we} !== {16'h4001, 16'hBEEF, 1'b1}) begin bad++; $display("FAIL write_bus addr=%h wdata=%h we=%b exp 4001/beef/1", o_addr, o_wdata, o_we); end
        total++; if (o_rdy_cyc != 5 || o_err_at !== 1'b0) begin bad++; $display("FAIL write_ready cyc=%0d err=%b exp 5/0", o_rdy_cyc, o_err_at); end
        total++; if (mdr_out !== 16'hBEEF || mar_out !== 16'h4001) begin bad++; $display("FAIL write_regs mdr=%h mar=%h exp beef/4001", mdr_out, mar_out); end
        mar_m = 16'h4001; mdr_m = 16'hBEEF;
    endtask

    task automatic test_timeout();
        do_access(0, 0, 0, 16'h0000, -1, 16'h0000, 0);
        total++; if (o_rdy_cyc != MAX_WAIT + 2 || o_err_at !== 1'b1) begin bad++; $display("FAIL timeout_ready cyc=%0d err=%b exp %0d/1", o_rdy_cyc, o_err_at, MAX_WAIT + 2); end
        total++; if (o_rdy_cnt != 1 || o_err_cnt != 1) begin bad++; $display("FAIL timeout_pulses rdy=%0d err=%0d exp 1/1", o_rdy_cnt, o_err_cnt); end
        total++; if (mdr_out !== mdr_m || o_req_end !== 1'b0) begin bad++; $display("FAIL timeout_mdr mdr=%h req=%b exp %h/0", mdr_out, o_req_end, mdr_m); end
    endtask

    task automatic test_ack_at_max();
        do_access(0, 0, 0, 16'h0000, MAX_WAIT, 16'h7E57, 0);
        total++; if (o_rdy_cyc != MAX_WAIT + 2 || o_err_cnt != 0) begin bad++; $display("FAIL ackmax_ready cyc=%0d errs=%0d exp %0d/0", o_rdy_cyc, o_err_cnt, MAX_WAIT + 2); end
        total++; if (mdr_out !== 16'h7E57) begin bad++; $display("FAIL ackmax_mdr mdr=%h exp 7e57", mdr_out); end
        mdr_m = 16'h7E57;
        // One past the limit: times out, and the late ack lands in DONE and is ignored
        do_access(0, 0, 0, 16'h0000, MAX_WAIT + 1, 16'h0BAD, 0);
        total++; if (o_err_at !== 1'b1 || mdr_out !== 16'h7E57) begin bad++; $display("FAIL ackover err=%b mdr=%h exp 1/7e57", o_err_at, mdr_out); end
    endtask

    task automatic test_ignored_inputs();
        do_access(0, 0, 0, 16'h0000, 4, 16'h2468, 1);
        mdr_m = 16'h2468;
        total++; if (mar_out !== mar_m || mdr_out !== mdr_m) begin bad++; $display("FAIL ignore_regs mar=%h mdr=%h exp %h/%h", mar_out, mdr_out, mar_m, mdr_m); end
        total++; if (o_rdy_cnt != 1 || o_req_end !== 1'b0 || o_busy_end !== 1'b0) begin bad++; $display("FAIL ignore_no_second rdy=%0d req=%b busy=%b exp 1/0/0", o_rdy_cnt, o_req_end, o_busy_end); end
        // Spurious ack while idle
        mif.mem_ack = 1; mif.mem_rdata = 16'hFACE; step(); idle_inputs();
        begin
            int pulses = 0;
            for (int c = 0; c < 4; c++) begin
                if (ready || err || busy) pulses++;
                step();
            end
            total++; if (pulses != 0 || mdr_out !== mdr_m) begin bad++; $display("FAIL spurious_ack act=%0d mdr=%h exp 0/%h", pulses, mdr_out, mdr_m); end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic        lmar, lmdr, rw;
            logic [15:0] bus, rdata, e_addr, e_wdata;
            int          delay;
            lmar  = 1'($urandom); lmdr = 1'($urandom); rw = 1'($urandom);
            bus   = 16'($urandom); rdata = 16'($urandom);
            delay = $urandom_range(0, 4) == 0 ? -1 : int'($urandom_range(0, MAX_WAIT + 1));
            e_addr  = lmar ? bus : mar_m;
            e_wdata = lmdr ? bus : mdr_m;
            if (lmar) mar_m = bus;
            if (lmdr) mdr_m = bus;
            do_access(lmar, lmdr, rw, bus, delay, rdata, 1'($urandom));
            if (!rw && delay >= 0 && delay <= MAX_WAIT) mdr_m = rdata;
            total++; if ({o_addr, o_wdata, o_we, o_req} !== {e_addr, e_wdata, rw, 1'b1}) begin
                bad++; $display("FAIL rnd%0d_bus addr=%h wdata=%h we=%b req=%b exp %h/%h/%b/1", t, o_addr, o_wdata, o_we, o_req, e_addr, e_wdata, rw);
            end
            total++; if (o_rdy_cyc != exp_ready_cyc(delay) || o_rdy_cnt != 1 || o_err_at !== !(delay >= 0 && delay <= MAX_WAIT)) begin
                bad++; $display("FAIL rnd%0d_ready cyc=%0d cnt=%0d err=%b delay=%0d exp cyc %0d", t, o_rdy_cyc, o_rdy_cnt, o_err_at, delay, exp_ready_cyc(delay));
            end
            total++; if (mar_out !== mar_m || mdr_out !== mdr_m) begin
                bad++; $display("FAIL rnd%0d_regs mar=%h mdr=%h exp %h/%h", t, mar_out, mdr_out, mar_m, mdr_m);
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_reg_load();
        test_read_zero_wait();
        test_write_wait3();
        test_timeout();
        test_ack_at_max();
        test_ignored_inputs();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- LC-3 MAR/MDR memory access sequencer: the consumer of the address side of the datapath.
- Latches addresses and data from the CPU bus, then runs single read or write transactions to the external memory (iCE40 BRAM/SPRAM wrapper) over a req/ack handshake.
- Returns the read data in MDR and signals completion to the control FSM with the LC-3 "R" (ready) pulse.
- Bounded wait states with timeout, so a dead memory cannot hang the CPU.

Parameters:
- MAX_WAIT, 15, cycles in ACCESS with no ack before the access is aborted (1..255).
- WAIT_W, 8, width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- bus_in  input  16  CPU bus value.
- ld_mar  input  1  load MAR from bus_in.
- ld_mdr  input  1  load MDR from bus_in (register load, no memory access).
- mem_en  input  1  start a memory access (1-cycle pulse from the control FSM).
- r_w  input  1  access type, sampled with mem_en: 0 = read, 1 = write.
- mar_out  output  16  current MAR.
- mdr_out  output  16  current MDR (drives the GateMDR path).
- ready  output  1  1-cycle pulse: access finished (LC-3 R).
- err  output  1  1-cycle pulse, coincident with ready, when the access timed out.
- busy  output  1  high while state != IDLE.
- mem_addr  output  16  address to memory, registered.
- mem_wdata  output  16  write data, registered.
- mem_we  output  1  write enable, registered, valid while mem_req is high.
- mem_req  output  1  request, registered.
- mem_rdata  input  16  read data, valid when mem_ack is high.
- mem_ack  input  1  memory completion.

Behaviour:
- Reset (rst high at a clock edge): state = IDLE; MAR, MDR, mem_addr and mem_wdata = 16'h0000; mem_req, mem_we, ready, err = 0; wait counter = 0. Reset mid-access abandons the transaction; no ready pulse is produced.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - ld_mar: MAR <= bus_in.
  - ld_mdr: MDR <= bus_in.
  - Both may load in the same cycle.
  - mem_en: go to ACCESS and assert mem_req the next cycle.
    - mem_addr <= (ld_mar ? bus_in : MAR), i.e. same-cycle address forwarding.
    - mem_wdata <= (ld_mdr ? bus_in : MDR).
    - mem_we <= r_w.
    - Wait counter cleared.
- ACCESS:
  - mem_req held high; mem_addr, mem_wdata and mem_we held stable.
  - ld_mar, ld_mdr and mem_en are ignored (no effect, no queuing).
  - mem_ack high:
    - Read: MDR <= mem_rdata.
    - Read or write: mem_req <= 0, mem_we <= 0, go to DONE.
  - No ack: counter increments. When the counter equals MAX_WAIT and ack is still low: mem_req <= 0, go to DONE with the error flag set, MDR unchanged.
  - Ack in the same cycle as the counter reaching MAX_WAIT: ack wins, no error.
- DONE:
  - ready = 1 for exactly one cycle; err = 1 in that cycle only if the access timed out.
  - Return to IDLE next cycle.
  - ld_* and mem_en in DONE are ignored.
- Latency:
  - mem_en at edge N gives mem_req high after N.
  - Earliest ack sampled at edge N+1; ready high after N+2. The zero-wait access is 2 cycles to DONE.
  - Each ack wait cycle adds 1.
  - Timeout: ready/err high MAX_WAIT+2 cycles after mem_en.
- mem_ack while not in ACCESS is ignored.
- mem_req is never asserted for two back-to-back transactions without one IDLE cycle in between.
- busy = (state != IDLE), combinational from state.

Test Plan:
- Reset → all outputs 0 and state IDLE; assert rst during ACCESS (ack never comes) → next cycle mem_req=0, and no ready or err pulse follows.
- ld_mar with bus=16'h3000; then mem_en, r_w=0; memory acks 1 cycle after req with rdata=16'h1234 → mem_addr=16'h3000, mem_we=0, MDR=16'h1234, ready pulses once, 2 cycles after mem_en.
- ld_mdr with bus=16'hBEEF, then ld_mar together with mem_en, r_w=1, bus=16'h4001; ack after 3 wait cycles → mem_addr=16'h4001, mem_wdata=16'hBEEF, mem_we=1, MDR stays 16'hBEEF, ready 5 cycles after mem_en.
- Read with ack never asserted, MAX_WAIT=15 → mem_req drops, ready and err pulse together 17 cycles after mem_en, MDR unchanged.
- Read with ack arriving exactly at wait count 15 → err=0, MDR takes rdata.
- During ACCESS drive ld_mar=1 with bus=16'hFFFF, plus mem_en and a spurious ack while in IDLE → MAR unchanged, no second transaction, spurious ack has no effect.
